rca6_mw_seq: RTL and testbench

Multi-word sequencer that drives the 6-bit ripple-carry adder stage (RCA6) to add operands wider than 6 bits, one 6-bit word per clock, LSW first. Each cycle it presents one operand word pair plus the carry from the previous word, captures the adder's sum and carry-out, and moves the carry forward. On completion it presents the full-width sum and final carry with a one-cycle Done pulse. It sits directly upstream of RCA6 and is also its only consumer.

---
 rtl/rca6_mw_seq.sv | 127 ++++++++++++
 tb/tb_rca6_mw_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rca6_mw_seq.sv
// rca6_mw_seq: multi-word sequencer driving a 6-bit ripple-carry adder stage.
// Adds two 6*NWORDS-bit operands one 6-bit word per clock, LSW first, and
// presents the full sum and final carry with a one-cycle Done pulse.
// Optional feature: define RCA6_SEQ_OVF_EN to add the signed-overflow output Ovf.
module rca6_mw_seq #(
    parameter int NWORDS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [6*NWORDS-1:0]   OpA,
    input  logic [6*NWORDS-1:0]   OpB,
    input  logic                  CinIn,
    output logic                  Busy,
    output logic                  Done,
    output logic [6*NWORDS-1:0]   Sum,
    output logic                  CoutOut,
`ifdef RCA6_SEQ_OVF_EN
    output logic                  Ovf,
`endif
    output logic [5:0]            A,
    output logic [5:0]            B,
    output logic                  Cin,
    input  logic [5:0]            So,
    input  logic                  Cout
);

    localparam int W  = 6 * NWORDS;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  op_a_l;
    logic [W-1:0]  op_b_l;

    // Operand latches: captured on an accepted Start, otherwise held.
    // NOTE: no reset here on purpose; A/B are forced to 0 outside ADD, so the
    // latched operand value is never observable until a Start overwrites it.
    always_ff @(posedge CLK) begin
        if (state == ST_IDLE && Start && !RST) begin
            op_a_l <= OpA;
            op_b_l <= OpB;
        end
    end

    // Sequencer FSM: word index, carry chain, result capture and status flags.
    // NOTE: every register here uses <= so all updates see pre-edge values,
    // e.g. the Sum slice indexed by k uses the old k, not k+1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Sum     <= '0;
            CoutOut <= 1'b0;
            carry   <= 1'b0;
            k       <= '0;
`ifdef RCA6_SEQ_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        carry   <= CinIn;
                        k       <= '0;
                        Sum     <= '0;
                        CoutOut <= 1'b0;
`ifdef RCA6_SEQ_OVF_EN
                        Ovf     <= 1'b0;
`endif
                        Busy    <= 1'b1;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    Sum[k*6 +: 6] <= So;
                    carry         <= Cout;
                    if (k == K_LAST) begin
                        CoutOut <= Cout;
`ifdef RCA6_SEQ_OVF_EN
                        Ovf     <= (A[5] == B[5]) && (So[5] != A[5]);
`endif
                        k       <= '0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Adder-facing word select: current operand words and carry during ADD, else 0.
    // NOTE: defaults assigned first so no path leaves an output unassigned (no latch).
    always_comb begin
        A   = '0;
        B   = '0;
        Cin = 1'b0;
        if (state == ST_ADD) begin
            A   = op_a_l[k*6 +: 6];
            B   = op_b_l[k*6 +: 6];
            Cin = carry;
        end
    end

endmodule

// File: tb/tb_rca6_mw_seq.sv
// Self-checking bench for rca6_mw_seq (NWORDS=4, W=24) with a behavioural RCA6.
module tb_rca6_mw_seq;

    localparam int NW = 4;
    localparam int W  = 6 * NW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Start;
    logic [W-1:0]  OpA, OpB;
    logic          CinIn;
    logic          Busy, Done, CoutOut;
    logic [W-1:0]  Sum;
    logic [5:0]    A, B, So;
    logic          Cin, Cout;
`ifdef RCA6_SEQ_OVF_EN
    logic          Ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    // Behavioural RCA6: combinational 6-bit add with carry.
    assign {Cout, So} = {1'b0, A} + {1'b0, B} + {6'b0, Cin};

    rca6_mw_seq #(.NWORDS(NW)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .OpA(OpA), .OpB(OpB), .CinIn(CinIn),
        .Busy(Busy), .Done(Done), .Sum(Sum), .CoutOut(CoutOut),
`ifdef RCA6_SEQ_OVF_EN
        .Ovf(Ovf),
`endif
        .A(A), .B(B), .Cin(Cin), .So(So), .Cout(Cout)
    );

    typedef struct {
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " A"}, 32'(A), 32'd0);
        check({tag, " B"}, 32'(B), 32'd0);
        check({tag, " Cin"}, 32'(Cin), 32'd0);
    endtask

    // One full operation: Start accepted at the next edge, then per-cycle checks.
    task automatic run_op(input vec_t v, input string tag);
        logic       c;
        logic [6:0] t;
        @(negedge CLK);
        OpA = v.opa; OpB = v.opb; CinIn = v.cin; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        c = v.cin;
        for (int i = 0; i < NW; i++) begin
            check({tag, " busy"}, 32'(Busy), 32'd1);
            check({tag, " done_early"}, 32'(Done), 32'd0);
            check({tag, " word_a"}, 32'(A), 32'(v.opa[6*i +: 6]));
            check({tag, " word_b"}, 32'(B), 32'(v.opb[6*i +: 6]));
            check({tag, " word_cin"}, 32'(Cin), 32'(c));
            if (i == 0) check({tag, " sum_cleared"}, 32'(Sum), 32'd0);
            t = {1'b0, v.opa[6*i +: 6]} + {1'b0, v.opb[6*i +: 6]} + {6'b0, c};
            c = t[6];
            @(negedge CLK);
        end
        check({tag, " done"}, 32'(Done), 32'd1);
        check({tag, " busy_off"}, 32'(Busy), 32'd0);
        check({tag, " sum"}, 32'(Sum), 32'(v.sum));
        check({tag, " cout"}, 32'(CoutOut), 32'(v.cout));
`ifdef RCA6_SEQ_OVF_EN
        check({tag, " ovf"}, 32'(Ovf), 32'(v.ovf));
`endif
        check_idle_outputs({tag, " done_state"});
        @(negedge CLK);
        check({tag, " done_pulse"}, 32'(Done), 32'd0);
        check({tag, " sum_hold"}, 32'(Sum), 32'(v.sum));
    endtask

    initial begin
        //           opa         opb         cin   sum         cout  ovf
        vecs[0] = '{24'h000001, 24'h00003F, 1'b0, 24'h000040, 1'b0, 1'b0};
        vecs[1] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0};
        vecs[2] = '{24'h123456, 24'h654321, 1'b1, 24'h777778, 1'b0, 1'b0};
        vecs[3] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1};
        vecs[4] = '{24'hABCDEF, 24'h111111, 1'b0, 24'hBCDF00, 1'b0, 1'b0};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{24'h000000, 24'h000000, 1'b1, 24'h000001, 1'b0, 1'b0};
        vecs[7] = '{24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1};

        RST = 1'b1; Start = 1'b0; OpA = '0; OpB = '0; CinIn = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst done", 32'(Done), 32'd0);
        check("rst sum", 32'(Sum), 32'd0);
        check("rst cout", 32'(CoutOut), 32'd0);
`ifdef RCA6_SEQ_OVF_EN
        check("rst ovf", 32'(Ovf), 32'd0);
`endif
        check_idle_outputs("rst");
        RST = 1'b0;

        // Hand-computed word sequence for 0x123456 + 0x654321 (words LSW first).
        begin
            logic [5:0] ea [4] = '{6'h16, 6'h11, 6'h23, 6'h04};
            logic [5:0] eb [4] = '{6'h21, 6'h0C, 6'h14, 6'h19};
            @(negedge CLK);
            OpA = 24'h123456; OpB = 24'h654321; CinIn = 1'b1; Start = 1'b1;
            @(negedge CLK);
            Start = 1'b0;
            for (int i = 0; i < NW; i++) begin
                check("seq word_a", 32'(A), 32'(ea[i]));
                check("seq word_b", 32'(B), 32'(eb[i]));
                @(negedge CLK);
            end
            check("seq done", 32'(Done), 32'd1);
            check("seq sum", 32'(Sum), 32'h777778);
        end

        // Table-driven operations.
        for (int n = 0; n < 8; n++) run_op(vecs[n], $sformatf("vec%0d", n));

        // Start held during ADD and DONE with other operands: must be ignored.
        @(negedge CLK);
        OpA = 24'h000FFF; OpB = 24'h000001; CinIn = 1'b0; Start = 1'b1;
        @(negedge CLK);
        OpA = 24'hFFFFFF; OpB = 24'hFFFFFF; CinIn = 1'b1;
        for (int i = 0; i < NW; i++) begin
            check("ign busy", 32'(Busy), 32'd1);
            check("ign word_a", 32'(A), (i == 0) ? 32'h3F : (i == 1) ? 32'h3F : 32'h00);
            @(negedge CLK);
        end
        check("ign done", 32'(Done), 32'd1);
        check("ign sum", 32'(Sum), 32'h001000);
        check("ign cout", 32'(CoutOut), 32'd0);
        Start = 1'b0;
        @(negedge CLK);
        check("ign not_queued", 32'(Busy), 32'd0);
        check("ign sum_hold", 32'(Sum), 32'h001000);
        run_op(vecs[5], "after_ign");

        // Reset in the second ADD cycle discards the operation.
        @(negedge CLK);
        OpA = 24'h123456; OpB = 24'h654321; CinIn = 1'b1; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst busy", 32'(Busy), 32'd0);
        check("mid_rst done", 32'(Done), 32'd0);
        check("mid_rst sum", 32'(Sum), 32'd0);
        check("mid_rst cout", 32'(CoutOut), 32'd0);
        check_idle_outputs("mid_rst");
        for (int i = 0; i < NW + 2; i++) begin
            @(negedge CLK);
            check("mid_rst no_done", 32'(Done), 32'd0);
            check("mid_rst idle", 32'(Busy), 32'd0);
        end
        run_op(vecs[2], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
